// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg : shared state encoding, opcode length field and len_of() helper
// Revision  : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_f_op   = 3'd1;
    localparam logic [2:0] c_st_f_opnd = 3'd2;
    localparam logic [2:0] c_st_hold   = 3'd3;
    localparam logic [2:0] c_st_load   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = c_st_idle,
        ST_F_OP   = c_st_f_op,
        ST_F_OPND = c_st_f_opnd,
        ST_HOLD   = c_st_hold,
        ST_LOAD   = c_st_load
    } state_t;

    localparam int c_len_msb   = 7;
    localparam int c_len_lsb   = 6;
    localparam int c_reset_pc  = 0;

    // Length field 00->0, 01->1, 1x->2, clamped to the configured maximum.
    function automatic logic [1:0] len_of(input logic [1:0] field,
                                          input logic [1:0] max_ops);
        logic [1:0] raw;
        raw = field[1] ? 2'd2 : {1'b0, field[0]};
        return (raw > max_ops) ? max_ops : raw;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_operand_shift_reg.sv
// -----------------------------------------------------------------------------
// operand_shift_reg : MAX_OPS x DATA_W operand store with indexed write and clear
// Revision          : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module operand_shift_reg
    import fetch_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int MAX_OPS = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clr,
    input  logic                        wr_en,
    input  logic [1:0]                  wr_idx,
    input  logic [DATA_W-1:0]           wr_data,
    output logic [MAX_OPS*DATA_W-1:0]   data
);

    logic [DATA_W-1:0] r_bytes [MAX_OPS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_OPS; i++) r_bytes[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < MAX_OPS; i++) r_bytes[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < MAX_OPS; i++)
                if (wr_idx == 2'(i)) r_bytes[i] <= wr_data;
        end
    end

    generate
        for (genvar g = 0; g < MAX_OPS; g++) begin : g_pack
            assign data[g*DATA_W +: DATA_W] = r_bytes[g];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit : variable-length instruction fetch and RAM-to-acc load over a
//              byte-wide req/ack memory port, valid/ready hand-off to decoder
// Revision   : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter int                MAX_OPS  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(c_reset_pc)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_W-1:0]           mem_data_in,
    input  logic                        mem_ack,
    output logic                        mem_req,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic                        pc_load,
    input  logic [ADDR_W-1:0]           pc_in,
    input  logic                        ld_req,
    input  logic [ADDR_W-1:0]           ld_addr,
    output logic [DATA_W-1:0]           instr,
    output logic [MAX_OPS*DATA_W-1:0]   operands,
    output logic [1:0]                  op_count,
    output logic                        instr_valid,
    input  logic                        instr_ready,
    output logic [DATA_W-1:0]           acc,
    output logic                        acc_valid,
    output logic [ADDR_W-1:0]           pc,
    output logic                        busy
);

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_pc, r_ld_addr, r_pc_pend;
    logic                r_pend_vld;
    logic [DATA_W-1:0]   r_instr, r_acc;
    logic [1:0]          r_op_count, r_k;
    logic                r_acc_valid;
    logic                w_mem_req, w_opnd_clr, w_opnd_wr;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [1:0]          w_len;

    assign w_len = len_of(mem_data_in[c_len_msb:c_len_lsb], 2'(MAX_OPS));

    always_comb begin
        w_state_nxt = r_state;
        w_mem_req   = 1'b0;
        w_mem_addr  = r_pc;
        w_opnd_clr  = 1'b0;
        w_opnd_wr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (pc_load)     w_state_nxt = ST_IDLE;
                else if (ld_req) w_state_nxt = ST_LOAD;
                else             w_state_nxt = ST_F_OP;
            end
            ST_F_OP: begin
                w_mem_req = 1'b1;
                if (pc_load) begin
                    w_state_nxt = ST_IDLE;
                end else if (mem_ack) begin
                    w_opnd_clr  = 1'b1;
                    w_state_nxt = (w_len == 2'd0) ? ST_HOLD : ST_F_OPND;
                end
            end
            ST_F_OPND: begin
                w_mem_req = 1'b1;
                if (pc_load) begin
                    w_state_nxt = ST_IDLE;
                end else if (mem_ack) begin
                    w_opnd_wr = 1'b1;
                    if (r_k + 2'd1 == r_op_count) w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (pc_load || instr_ready) w_state_nxt = ST_IDLE;
            end
            ST_LOAD: begin
                w_mem_req  = 1'b1;
                w_mem_addr = r_ld_addr;
                if (mem_ack) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_pc        <= RESET_PC;
            r_ld_addr   <= '0;
            r_pc_pend   <= '0;
            r_pend_vld  <= 1'b0;
            r_instr     <= '0;
            r_acc       <= '0;
            r_op_count  <= '0;
            r_k         <= '0;
            r_acc_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!pc_load && ld_req) r_ld_addr <= ld_addr;
                end
                ST_F_OP: begin
                    if (!pc_load && mem_ack) begin
                        r_instr    <= mem_data_in;
                        r_pc       <= r_pc + ADDR_W'(1);
                        r_op_count <= w_len;
                        r_k        <= '0;
                    end
                end
                ST_F_OPND: begin
                    if (!pc_load && mem_ack) begin
                        r_pc <= r_pc + ADDR_W'(1);
                        r_k  <= r_k + 2'd1;
                    end
                end
                // A jump seen during a load waits until the load has completed.
                ST_LOAD: begin
                    if (mem_ack) begin
                        r_acc       <= mem_data_in;
                        r_acc_valid <= 1'b1;
                        r_pend_vld  <= 1'b0;
                        if (pc_load)         r_pc <= pc_in;
                        else if (r_pend_vld) r_pc <= r_pc_pend;
                    end else if (pc_load) begin
                        r_pend_vld <= 1'b1;
                        r_pc_pend  <= pc_in;
                    end
                end
                default: ;
            endcase
            if (pc_load && r_state != ST_LOAD) r_pc <= pc_in;
        end
    end

    operand_shift_reg #(
        .DATA_W  (DATA_W),
        .MAX_OPS (MAX_OPS)
    ) u_opnd (
        .clk     (clk),
        .reset   (reset),
        .clr     (w_opnd_clr),
        .wr_en   (w_opnd_wr),
        .wr_idx  (r_k),
        .wr_data (mem_data_in),
        .data    (operands)
    );

    assign mem_req     = w_mem_req;
    assign mem_addr    = w_mem_addr;
    assign instr       = r_instr;
    assign op_count    = r_op_count;
    assign instr_valid = (r_state == ST_HOLD);
    assign acc         = r_acc;
    assign acc_valid   = r_acc_valid;
    assign pc          = r_pc;
    assign busy        = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit : directed self-checking bench for fetch_unit
// Revision      : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  mem_data_in = '0;
    logic        mem_ack = 1'b0;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        pc_load = 1'b0;
    logic [7:0]  pc_in = '0;
    logic        ld_req = 1'b0;
    logic [7:0]  ld_addr = '0;
    logic [7:0]  instr;
    logic [15:0] operands;
    logic [1:0]  op_count;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [7:0]  acc;
    logic        acc_valid;
    logic [7:0]  pc;
    logic        busy;

    int n_err = 0;
    int n_chk = 0;

    logic [7:0] mem [256];
    logic       resp_en = 1'b1;
    int         wait_n  = 0;
    int         cnt     = 0;

    fetch_unit #(.DATA_W(8), .ADDR_W(8), .MAX_OPS(2), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_data_in (mem_data_in),
        .mem_ack     (mem_ack),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .pc_load     (pc_load),
        .pc_in       (pc_in),
        .ld_req      (ld_req),
        .ld_addr     (ld_addr),
        .instr       (instr),
        .operands    (operands),
        .op_count    (op_count),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .acc         (acc),
        .acc_valid   (acc_valid),
        .pc          (pc),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Memory model: acks after wait_n idle cycles of an outstanding request.
    initial begin
        forever begin
            @(negedge clk);
            if (resp_en) begin
                if (mem_req && reset) begin
                    if (cnt >= wait_n) begin
                        mem_ack     = 1'b1;
                        mem_data_in = mem[mem_addr];
                        cnt         = 0;
                    end else begin
                        mem_ack = 1'b0;
                        cnt     = cnt + 1;
                    end
                end else begin
                    mem_ack = 1'b0;
                    cnt     = 0;
                end
            end
        end
    end

    task automatic chk8(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic wait_valid(input string name, input int budget);
        int c;
        c = 0;
        while (instr_valid !== 1'b1 && c < budget) begin
            @(negedge clk);
            c++;
        end
        n_chk++;
        if (instr_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s: instr_valid not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        chk8("rst_pc", 16'(pc), 16'h00);
        chk8("rst_instr", 16'(instr), 16'h00);
        chk8("rst_operands", operands, 16'h0000);
        chk8("rst_op_count", 16'(op_count), 16'h0);
        chk8("rst_acc", 16'(acc), 16'h00);
        chk8("rst_flags", {13'b0, mem_req, instr_valid, acc_valid}, 16'h0);
    endtask

    task automatic test_single_byte();
        @(negedge clk);
        chk8("t1_req", 16'(mem_req), 16'h1);
        chk8("t1_addr", 16'(mem_addr), 16'h00);
        @(negedge clk);
        chk8("t1_valid_cycle", 16'(instr_valid), 16'h1);
        chk8("t1_instr", 16'(instr), 16'h05);
        chk8("t1_op_count", 16'(op_count), 16'h0);
        chk8("t1_pc", 16'(pc), 16'h01);
    endtask

    task automatic test_hold_stall();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk8("t3_hold", {6'b0, instr_valid, mem_req, instr}, {6'b0, 1'b1, 1'b0, 8'h05});
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        chk8("t3_idle", 16'(instr_valid), 16'h0);
        @(negedge clk);
        chk8("t3_next_addr", {7'b0, mem_req, mem_addr}, {7'b0, 1'b1, 8'h01});
        wait_valid("t3_next_valid", 10);
    endtask

    task automatic test_wait_states();
        logic [7:0] seq [$];
        logic [7:0] exp_seq [9];
        int c;
        exp_seq = '{8'h10, 8'h10, 8'h10, 8'h11, 8'h11, 8'h11, 8'h12, 8'h12, 8'h12};
        wait_n  = 2;
        pc_load = 1'b1;
        pc_in   = 8'h10;
        @(negedge clk);
        pc_load = 1'b0;
        chk8("t2_pc_jump", 16'(pc), 16'h10);
        c = 0;
        while (instr_valid !== 1'b1 && c < 40) begin
            if (mem_req) seq.push_back(mem_addr);
            @(negedge clk);
            c++;
        end
        chk8("t2_req_cycles", 16'(seq.size()), 16'd9);
        for (int i = 0; i < 9 && i < seq.size(); i++)
            chk8("t2_addr_seq", 16'(seq[i]), 16'(exp_seq[i]));
        chk8("t2_valid", 16'(instr_valid), 16'h1);
        chk8("t2_instr", 16'(instr), 16'h8A);
        chk8("t2_operands", operands, 16'h1234);
        chk8("t2_op_count", 16'(op_count), 16'h2);
        chk8("t2_pc", 16'(pc), 16'h13);
        wait_n = 0;
    endtask

    task automatic test_load();
        ld_req      = 1'b1;
        ld_addr     = 8'h80;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        @(negedge clk);
        ld_req = 1'b0;
        chk8("t4_load_addr", {7'b0, mem_req, mem_addr}, {7'b0, 1'b1, 8'h80});
        @(negedge clk);
        chk8("t4_acc", 16'(acc), 16'hA5);
        chk8("t4_acc_valid", 16'(acc_valid), 16'h1);
        chk8("t4_pc_kept", 16'(pc), 16'h13);
        @(negedge clk);
        chk8("t4_acc_pulse", 16'(acc_valid), 16'h0);
        wait_valid("t4_after_load", 10);
        chk8("t4_pc_after", 16'(pc), 16'h14);
    endtask

    task automatic test_jump_abort();
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk8("t5_in_opnd", {7'b0, mem_ack, mem_addr}, {7'b0, 1'b1, 8'h15});
        pc_load = 1'b1;
        pc_in   = 8'h40;
        @(negedge clk);
        pc_load = 1'b0;
        chk8("t5_valid_low", 16'(instr_valid), 16'h0);
        chk8("t5_pc", 16'(pc), 16'h40);
        chk8("t5_discard", operands, 16'h0000);
        @(negedge clk);
        chk8("t5_next_addr", {7'b0, mem_req, mem_addr}, {7'b0, 1'b1, 8'h40});
        wait_valid("t5_after", 10);
    endtask

    task automatic test_wrap_and_reset();
        pc_load = 1'b1;
        pc_in   = 8'hFF;
        @(negedge clk);
        pc_load = 1'b0;
        wait_valid("t6_wrap_valid", 10);
        chk8("t6_instr", 16'(instr), 16'h41);
        chk8("t6_operands", operands, 16'h003C);
        chk8("t6_op_count", 16'(op_count), 16'h1);
        chk8("t6_pc", 16'(pc), 16'h01);
        wait_n      = 20;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        @(negedge clk);
        chk8("t6_in_fop", {7'b0, mem_req, mem_addr}, {7'b0, 1'b1, 8'h01});
        resp_en = 1'b0;
        mem_ack = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk8("t6_async", {5'b0, mem_req, instr_valid, acc_valid, pc}, 16'h0000);
        chk8("t6_async_data", {instr, acc}, 16'h0000);
        chk8("t6_async_ops", {14'b0, op_count}, 16'h0);
        chk8("t6_async_operands", operands, 16'h0000);
        @(negedge clk);
        chk8("t6_late_ack", {busy, instr, 7'b0}, 16'h0000);
        mem_ack = 1'b0;
        resp_en = 1'b1;
        wait_n  = 0;
        reset   = 1'b1;
        @(negedge clk);
        chk8("t6_restart", {7'b0, mem_req, mem_addr}, {7'b0, 1'b1, 8'h00});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h05;
        mem[8'h10] = 8'h8A;
        mem[8'h11] = 8'h34;
        mem[8'h12] = 8'h12;
        mem[8'h14] = 8'h9C;
        mem[8'h15] = 8'h77;
        mem[8'h16] = 8'h66;
        mem[8'h80] = 8'hA5;
        mem[8'hFF] = 8'h41;

        test_reset();
        test_single_byte();
        test_hold_stall();
        test_wait_states();
        test_load();
        test_jump_abort();
        mem[8'h00] = 8'h3C;
        test_wrap_and_reset();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised successor to the single-byte fetcher. Fetches variable-length instructions (opcode plus 0..MAX_OPS operand bytes) and RAM data loads into the accumulator over one byte-wide memory port with a req/ack handshake, so memory may insert wait states. It owns the PC and hands complete instructions to the decoder via a valid/ready handshake. It sits between the memory mux and the decoder.

Parameters:
DATA_W, 8, width of memory data, instr, operand bytes and acc
ADDR_W, 8, width of memory address and PC
MAX_OPS, 2, maximum operand bytes per instruction (1..3)
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
mem_data_in  in  DATA_W  memory read data, valid when mem_ack=1
mem_ack  in  1  memory completes the current request this cycle
mem_req  out  1  memory request, held until mem_ack
mem_addr  out  ADDR_W  request address, stable while mem_req=1
pc_load  in  1  jump: load pc_in, abort any fetch in progress
pc_in  in  ADDR_W  jump target
ld_req  in  1  decoder requests a RAM load into acc (accepted only in IDLE)
ld_addr  in  ADDR_W  RAM load address, sampled when ld_req is accepted
instr  out  DATA_W  opcode of the held instruction
operands  out  MAX_OPS*DATA_W  operand bytes; byte 0 in the LSBs
op_count  out  2  number of valid operand bytes
instr_valid  out  1  instr/operands valid
instr_ready  in  1  decoder accepts the instruction
acc  out  DATA_W  accumulator loaded by RAM load
acc_valid  out  1  one-cycle pulse when acc updates
pc  out  ADDR_W  address of the next byte to fetch
busy  out  1  state != IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE; pc=RESET_PC. instr, operands, op_count, acc = 0. mem_req, instr_valid, acc_valid = 0. Mid-transaction reset aborts immediately; a late mem_ack is ignored.
- States: IDLE, F_OP, F_OPND, HOLD, LOAD.
- Operand count comes from opcode bits [7:6]: 00→0, 01→1, 1x→2. The result is clamped to MAX_OPS. Packing this is the function len_of().
- IDLE:
  - If ld_req=1, latch ld_addr and go to LOAD.
  - Otherwise go to F_OP.
  - ld_req has priority over instruction fetch.
- F_OP: mem_req=1, mem_addr=pc. On mem_ack:
  - instr<=mem_data_in; pc<=pc+1 (mod 2^ADDR_W, wraps FF→00).
  - Clear operands; op_count<=len_of(data).
  - If the count is 0, go to HOLD. Otherwise go to F_OPND.
- F_OPND: mem_req=1, mem_addr=pc. Each mem_ack stores the byte at index k, increments pc and k. When k reaches op_count, go to HOLD.
- HOLD: instr_valid=1 and outputs stay stable. When instr_valid&instr_ready, go to IDLE.
  - Best-case latency is 1 cycle IDLE plus 1 per byte with zero wait states.
  - instr_valid first asserts the cycle after the last ack.
- LOAD: mem_req=1, mem_addr=latched ld_addr. On mem_ack, acc<=mem_data_in, acc_valid pulses 1 cycle, go to IDLE. pc is unchanged.
- mem_req stays high with a constant mem_addr until ack. Every ack is consumed once.
- pc_load (any state except LOAD):
  - pc<=pc_in; instr_valid<=0; go to IDLE next cycle.
  - A same-cycle mem_ack is discarded.
  - A same-cycle instr_ready handshake is discarded; the instruction is not delivered.
- pc_load in LOAD: it is registered as pending and applied on the transition to IDLE, so the load completes first.
- ld_req outside IDLE is ignored; the decoder must hold it.

Decomposition:
- Shared package fetch_pkg holds:
  - the state encoding (3-bit localparams)
  - opcode length-field position
  - len_of() function
  - RESET_PC default
- One sub-module is natural: operand_shift_reg (MAX_OPS×DATA_W indexed write, clear). The controller FSM stays in fetch_unit.

Test Plan:
1. Reset then ROM {00:0x05}, ack every cycle, ready=1 → mem_addr=00; instr=0x05, op_count=0, instr_valid at cycle 3; pc=01.
2. ROM {10:0x8A,11:0x34,12:0x12}, pc_in=0x10, ack delayed by 2 cycles each → mem_addr steady during waits; operands=0x1234, op_count=2, pc=0x13.
3. HOLD with instr_ready=0 for 5 cycles → outputs stable and no mem_req; ready=1 → next fetch starts at the following address.
4. ld_req with ld_addr=0x80, RAM[0x80]=0xA5, asserted in IDLE → acc=0xA5, acc_valid 1-cycle pulse, pc unchanged.
5. pc_load to 0x40 during F_OPND with concurrent mem_ack → byte discarded, instr_valid stays 0, next mem_addr=0x40.
6. pc=0xFF, opcode 0x41 at FF and operand at 00 → wrap, operand fetched from 00, pc=01; then reset asserted mid-F_OP → all outputs 0 immediately, pc=RESET_PC.
